mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs, drives a req/ack data-memory bus, and produces the registered MEM/WB inputs. It stalls the upstream pipeline while a bus access is in flight and handles byte/half/word lane steering with sign or zero extension.

Parameters:
MAX_WAIT, 255, cycles allowed in REQ without dmem_ack before a bus error is raised (1..255).
XLEN, 32, data and address width.

Ports:
clk  in  1  clock; all logic samples on posedge.
reset  in  1  synchronous, active-low reset: low at a clk posedge resets the block.
RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control bits from EX/MEM.
funct3_in  in  3  access size and sign, using the RV32I load/store encoding.
alu_result_in  in  XLEN  effective address, or the ALU result for non-memory ops.
rs2_data_in  in  XLEN  store data.
rd_in  in  5  destination register.
stall  out  1  hold EX/MEM and earlier stages.
dmem_req  out  1  bus request.
dmem_we  out  1  1 = write.
dmem_addr  out  XLEN  word-aligned address.
dmem_wdata  out  XLEN  lane-shifted store data.
dmem_be  out  4  byte enables.
dmem_ack  in  1  transfer complete; ignored while dmem_req = 0.
dmem_rdata  in  XLEN  read word, valid with dmem_ack.
wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each  registered MEM/WB control.
wb_mem_data  out  XLEN  extended load data.
wb_alu_result  out  XLEN  passthrough of the ALU result.
wb_rd  out  5  passthrough of rd.
bus_err  out  1  one-cycle pulse on timeout.
misalign_exc  out  1  one-cycle misalignment pulse (see Optional Feature).

Behaviour:
- Reset: state IDLE. Every output is 0, including the dmem_* bus signals, stall, wb_*, bus_err and misalign_exc. The wait counter is 0. Reset taken mid-access drops dmem_req at that edge; any later ack is ignored.
- States:
  - IDLE: accept a new op.
  - REQ: bus access outstanding. No other states.
- Non-memory op (MemRead_in = MemWrite_in = 0) in IDLE: 1-cycle latency. wb_* load the inputs at the next edge with wb_valid = 1, wb_mem_data = 0, and no stall.
- Memory op in IDLE:
  - stall = 1 combinationally.
  - At the next edge the inputs are captured, the bus signals are registered, dmem_req = 1, and state goes to REQ.
  - If MemRead_in and MemWrite_in are both 1, the op is a store.
- stall = (state == REQ and not completing) or (IDLE and memory op present). stall falls in the ack cycle so upstream advances at the same edge the result is written.
- REQ: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until dmem_ack = 1.
  - At the ack edge: dmem_req goes to 0, state returns to IDLE, and wb_* load with wb_valid = 1.
  - Minimum load/store latency is 2 cycles (ack in the first REQ cycle).
- While stalled, wb_valid = 0 and wb_RegWrite = 0 (bubble).
- Address and lanes: dmem_addr = {addr[31:2], 2'b00}. Let k = addr[1:0].
  - Byte: be = 0001 << k; wdata = rs2[7:0] replicated ×4.
  - Half: be = 0011 << (2·addr[1]); wdata = rs2[15:0] replicated ×2.
  - Word: be = 1111.
  - Loads drive be as for stores, with dmem_we = 0.
- Load extract:
  - 000 LB: sign-extend byte k.
  - 100 LBU: zero-extend byte k.
  - 001 LH: sign-extend half addr[1].
  - 101 LHU: zero-extend half addr[1].
  - 010 LW: whole word.
  - 011, 110, 111: treated as word.
- Timeout: the counter increments each REQ cycle without ack. When it reaches MAX_WAIT:
  - dmem_req drops, bus_err pulses for 1 cycle, and state returns to IDLE.
  - The op completes with wb_valid = 1 and wb_RegWrite = 0.
  - The counter clears on every exit from REQ.
- An ack arriving in the same cycle the counter hits MAX_WAIT wins: normal completion, no bus_err.

Optional Feature:
MISALIGN_EXC_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no bus request.
  - The op completes in 1 cycle from IDLE with no stall, wb_valid = 1 and wb_RegWrite = 0.
  - misalign_exc pulses for 1 cycle, aligned with that wb_valid.
- Undefined: misalign_exc is tied to 0. Offending low address bits are truncated to natural alignment (half uses addr[1] only; word uses offset 0), and the access proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - the funct3 size/sign constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the state enum lsu_state_t {IDLE, REQ};
  - byte-enable width 4 and the byte-lane width constants.
- Sub-module lsu_load_align: combinational; takes rdata, addr[1:0] and funct3, and outputs the extended XLEN word. It is unit-testable on its own.

Test Plan:
- ALU op: alu_result_in = 0x1234, rd = 5, RegWrite = 1 → next cycle wb_valid = 1, wb_alu_result = 0x1234, wb_rd = 5, stall never 1.
- SB with addr 0x1003, rs2 = 0xAABBCCDD → dmem_addr = 0x1000, be = 1000, wdata = 0xDDDDDDDD, dmem_we = 1. Ack held off 3 cycles → stall high 4 cycles, request signals stable throughout.
- LB then LBU at addr 0x2001, rdata = 0x0000F000 with ack in the first REQ cycle → wb_mem_data = 0xFFFFFFF0, then 0x000000F0. Latency 2 cycles each.
- LH at addr 0x2002, rdata = 0x80010000 → wb_mem_data = 0xFFFF8001.
- Timeout: MAX_WAIT = 4, no ack → bus_err pulses on cycle 4 of REQ, dmem_req drops, wb_RegWrite = 0. A late ack afterwards is ignored.
- Reset low mid-REQ → next edge dmem_req = 0 and stall = 0. With MISALIGN_EXC_EN, LW at 0x3002 → misalign_exc = 1, dmem_req never asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, types and lane helpers for the memory-stage load/store unit.
package lsu_pkg;

    // RV32I load/store funct3 encodings (loads and stores share size bits).
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int BE_W   = 4;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic {
        IDLE,
        REQ
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Reserved size encodings fall through to a full-word access.
    function automatic lsu_size_t size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_enables(input logic [2:0] funct3,
                                                     input logic [1:0] addr_lo);
        case (size_of(funct3))
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data lane select with sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [BYTE_W-1:0] sel_byte;
    logic [HALF_W-1:0] sel_half;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sel_byte = rdata[BYTE_W*addr_lo +: BYTE_W];
        sel_half = rdata[HALF_W*addr_lo[1] +: HALF_W];
        case (funct3)
            LB:      data = {{(XLEN-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
            LBU:     data = {{(XLEN-BYTE_W){1'b0}}, sel_byte};
            LH:      data = {{(XLEN-HALF_W){sel_half[HALF_W-1]}}, sel_half};
            LHU:     data = {{(XLEN-HALF_W){1'b0}}, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: EX/MEM in, req/ack data bus, registered MEM/WB out.
// Build option: define MISALIGN_EXC_EN to trap misaligned half/word accesses.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_RegWrite,
    output logic            wb_MemtoReg,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [4:0]      wb_rd,
    output logic            bus_err,
    output logic            misalign_exc
);

    localparam int CNT_W = 8;

    lsu_state_t      state, state_next;
    logic [CNT_W-1:0] wait_cnt;

    // Op captured at issue so upstream may change once stall releases.
    logic            op_reg_write;
    logic            op_mem_to_reg;
    logic            op_is_load;
    logic [2:0]      op_funct3;
    logic [XLEN-1:0] op_alu;
    logic [4:0]      op_rd;

    logic            mem_op, misaligned;
    logic            start_bus, ack_done, timeout;
    logic [XLEN-1:0] store_wdata, load_data;

    assign mem_op = MemRead_in | MemWrite_in;

`ifdef MISALIGN_EXC_EN
    always_comb begin
        misaligned = 1'b0;
        if (mem_op) begin
            case (size_of(funct3_in))
                SZ_HALF: misaligned = alu_result_in[0];
                SZ_WORD: misaligned = (alu_result_in[1:0] != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (size_of(funct3_in))
            SZ_BYTE: store_wdata = {(XLEN/BYTE_W){rs2_data_in[BYTE_W-1:0]}};
            SZ_HALF: store_wdata = {(XLEN/HALF_W){rs2_data_in[HALF_W-1:0]}};
            default: store_wdata = rs2_data_in;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (op_alu[1:0]),
        .funct3  (op_funct3),
        .data    (load_data)
    );

    // The last permitted REQ cycle is wait_cnt == MAX_WAIT-1; an ack there still wins.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        start_bus  = 1'b0;
        ack_done   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    stall      = 1'b1;
                    start_bus  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset) stall = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            op_reg_write  <= 1'b0;
            op_mem_to_reg <= 1'b0;
            op_is_load    <= 1'b0;
            op_funct3     <= '0;
            op_alu        <= '0;
            op_rd         <= '0;
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemtoReg   <= 1'b0;
            wb_mem_data   <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
            bus_err       <= 1'b0;
            misalign_exc  <= 1'b0;
        end else begin
            state        <= state_next;
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            bus_err      <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_bus) begin
                        dmem_req      <= 1'b1;
                        dmem_we       <= MemWrite_in;
                        dmem_addr     <= {alu_result_in[XLEN-1:2], 2'b00};
                        dmem_be       <= byte_enables(funct3_in, alu_result_in[1:0]);
                        dmem_wdata    <= store_wdata;
                        wait_cnt      <= '0;
                        op_reg_write  <= RegWrite_in;
                        op_mem_to_reg <= MemtoReg_in;
                        op_is_load    <= MemRead_in & ~MemWrite_in;
                        op_funct3     <= funct3_in;
                        op_alu        <= alu_result_in;
                        op_rd         <= rd_in;
                    end else begin
                        wb_valid      <= 1'b1;
                        wb_RegWrite   <= RegWrite_in & ~misaligned;
                        wb_MemtoReg   <= MemtoReg_in;
                        wb_mem_data   <= '0;
                        wb_alu_result <= alu_result_in;
                        wb_rd         <= rd_in;
                        misalign_exc  <= misaligned;
                    end
                end
                REQ: begin
                    if (ack_done || timeout) begin
                        dmem_req      <= 1'b0;
                        wait_cnt      <= '0;
                        wb_valid      <= 1'b1;
                        wb_RegWrite   <= op_reg_write & ack_done;
                        wb_MemtoReg   <= op_mem_to_reg;
                        wb_mem_data   <= (ack_done && op_is_load) ? load_data : '0;
                        wb_alu_result <= op_alu;
                        wb_rd         <= op_rd;
                        bus_err       <= timeout;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized ops against a reference model.
module tb_mem_stage_lsu;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] alu_result_in, rs2_data_in;
    logic [4:0]      rd_in;
    logic            stall, dmem_req, dmem_we, dmem_ack;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]      dmem_be;
    logic            wb_valid, wb_RegWrite, wb_MemtoReg, bus_err, misalign_exc;
    logic [XLEN-1:0] wb_mem_data, wb_alu_result;
    logic [4:0]      wb_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite_in   (RegWrite_in),
        .MemtoReg_in   (MemtoReg_in),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .funct3_in     (funct3_in),
        .alu_result_in (alu_result_in),
        .rs2_data_in   (rs2_data_in),
        .rd_in         (rd_in),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemtoReg   (wb_MemtoReg),
        .wb_mem_data   (wb_mem_data),
        .wb_alu_result (wb_alu_result),
        .wb_rd         (wb_rd),
        .bus_err       (bus_err),
        .misalign_exc  (misalign_exc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model: access size in bytes, lane offset, lanes, extension ----
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input int sz, input logic [31:0] addr);
        if (sz == 1) return int'(addr % 4);
        if (sz == 2) return int'(addr % 4) & 2;
        return 0;
    endfunction

    function automatic logic is_misaligned(input logic mem, input int sz, input logic [31:0] addr);
`ifdef MISALIGN_EXC_EN
        return mem && ((sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] rs2);
        if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int sz, input int off,
                                               input logic [31:0] rdata);
        logic [31:0] v, mask;
        if (sz == 4) return rdata;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v = (rdata >> (8 * off)) & mask;
        if (!f3[2] && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
        return v;
    endfunction

    // Drives one op from IDLE, runs the bus handshake (ack after 'delay' waiting
    // REQ cycles, or never if delay >= MAX_WAIT) and checks every observable step.
    task automatic do_op(input logic regw, input logic m2r, input logic mrd, input logic mwr,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd, input int delay, input logic [31:0] rdata);
        int sz, off;
        logic mem, mis, acked, is_load;
        logic [31:0] e_be, e_wd, e_addr, e_load;
        sz      = size_bytes(f3);
        off     = lane_off(sz, addr);
        mem     = mrd | mwr;
        is_load = mrd & ~mwr;
        mis     = is_misaligned(mem, sz, addr);
        e_addr  = addr & 32'hFFFF_FFFC;
        e_be    = ((32'd1 << sz) - 1) << off;
        e_wd    = model_wdata(sz, rs2);
        e_load  = model_load(f3, sz, off, rdata);
        acked   = 1'b0;

        @(negedge clk);
        RegWrite_in = regw; MemtoReg_in = m2r; MemRead_in = mrd; MemWrite_in = mwr;
        funct3_in = f3; alu_result_in = addr; rs2_data_in = rs2; rd_in = rd;
        dmem_ack = 1'b0;
        #1;
        if (mem && !mis) begin
            check("stall_issue", stall, 1);
            @(posedge clk); #1;
            check("req_issue", dmem_req, 1);
            check("req_we", dmem_we, mwr);
            check("req_addr", dmem_addr, e_addr);
            check("req_be", dmem_be, e_be);
            if (mwr) check("req_wdata", dmem_wdata, e_wd);
            check("bubble_valid", wb_valid, 0);
            check("bubble_regwrite", wb_RegWrite, 0);
            // Upstream values are now don't-care; scramble them to prove capture.
            alu_result_in = $urandom; rs2_data_in = $urandom;
            funct3_in = 3'($urandom); rd_in = 5'($urandom);
            for (int c = 1; c <= MAX_WAIT; c++) begin
                @(negedge clk);
                dmem_ack   = (c == delay + 1);
                dmem_rdata = dmem_ack ? rdata : $urandom;
                #1;
                check("stall_req", stall, !(dmem_ack || c == MAX_WAIT));
                check("hold_req", dmem_req, 1);
                check("hold_we", dmem_we, mwr);
                check("hold_addr", dmem_addr, e_addr);
                check("hold_be", dmem_be, e_be);
                if (mwr) check("hold_wdata", dmem_wdata, e_wd);
                @(posedge clk); #1;
                if (dmem_ack) begin
                    acked = 1'b1;
                    break;
                end
            end
            dmem_ack = 1'b0;
            check("done_req", dmem_req, 0);
            check("done_valid", wb_valid, 1);
            check("done_regwrite", wb_RegWrite, regw & acked);
            check("done_memtoreg", wb_MemtoReg, m2r);
            check("done_mem_data", wb_mem_data, (acked && is_load) ? e_load : 32'd0);
            check("done_alu", wb_alu_result, addr);
            check("done_rd", wb_rd, rd);
            check("done_bus_err", bus_err, !acked);
            check("done_misalign", misalign_exc, 0);
        end else begin
            check("stall_idle", stall, 0);
            @(posedge clk); #1;
            check("idle_req", dmem_req, 0);
            check("idle_valid", wb_valid, 1);
            check("idle_regwrite", wb_RegWrite, regw & ~mis);
            check("idle_memtoreg", wb_MemtoReg, m2r);
            check("idle_mem_data", wb_mem_data, 0);
            check("idle_alu", wb_alu_result, addr);
            check("idle_rd", wb_rd, rd);
            check("idle_bus_err", bus_err, 0);
            check("idle_misalign", misalign_exc, mis);
        end
    endtask

    initial begin
        reset = 1'b0;
        RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        funct3_in = 0; alu_result_in = 0; rs2_data_in = 0; rd_in = 0;
        dmem_ack = 0; dmem_rdata = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_be", dmem_be, 0);
        check("rst_valid", wb_valid, 0);
        check("rst_regwrite", wb_RegWrite, 0);
        check("rst_memtoreg", wb_MemtoReg, 0);
        check("rst_mem_data", wb_mem_data, 0);
        check("rst_alu", wb_alu_result, 0);
        check("rst_rd", wb_rd, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_misalign", misalign_exc, 0);
        @(negedge clk);
        reset = 1'b1;

        // ALU op, stores, loads and timeout from the directed plan.
        do_op(1, 0, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
        do_op(0, 0, 0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 3, 32'h0);
        do_op(1, 1, 1, 0, 3'b000, 32'h0000_2001, 32'h0, 5'd7, 0, 32'h0000_F000);
        do_op(1, 1, 1, 0, 3'b100, 32'h0000_2001, 32'h0, 5'd8, 0, 32'h0000_F000);
        do_op(1, 1, 1, 0, 3'b001, 32'h0000_2002, 32'h0, 5'd9, 1, 32'h8001_0000);
        do_op(1, 1, 1, 0, 3'b101, 32'h0000_2002, 32'h0, 5'd10, 2, 32'h8001_0000);
        do_op(0, 0, 1, 1, 3'b001, 32'h0000_2006, 32'h1234_5678, 5'd0, 0, 32'h0);
        do_op(1, 1, 1, 0, 3'b010, 32'h0000_2008, 32'h0, 5'd11, MAX_WAIT + 2, 32'h0);

        // A late ack with no request outstanding must be ignored.
        @(negedge clk);
        RegWrite_in = 1; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
        alu_result_in = 32'h0000_00AA; rd_in = 5'd3; dmem_ack = 1'b1;
        #1;
        check("late_ack_stall", stall, 0);
        @(posedge clk); #1;
        check("late_ack_req", dmem_req, 0);
        check("late_ack_bus_err", bus_err, 0);
        check("late_ack_valid", wb_valid, 1);
        check("late_ack_alu", wb_alu_result, 32'h0000_00AA);
        dmem_ack = 1'b0;

        // Word at a non-word address: truncated by default, trapped when enabled.
        do_op(1, 1, 1, 0, 3'b010, 32'h0000_3002, 32'h0, 5'd12, 0, 32'hCAFE_F00D);
        do_op(0, 0, 0, 1, 3'b001, 32'h0000_3001, 32'hDEAD_BEEF, 5'd0, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [2:0] f3;
            kind = int'($urandom_range(0, 3));
            f3 = (kind >= 2) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            do_op(1'($urandom), 1'($urandom), kind == 1 || kind == 3, kind >= 2, f3,
                  $urandom, $urandom, 5'($urandom), int'($urandom_range(0, MAX_WAIT + 1)),
                  $urandom);
        end

        // Reset taken mid-access drops the request at that edge.
        @(negedge clk);
        RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 1; funct3_in = 3'b010;
        alu_result_in = 32'h0000_0040; rs2_data_in = 32'h5555_AAAA;
        @(posedge clk); #1;
        check("mid_req_up", dmem_req, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_stall_low", stall, 0);
        @(posedge clk); #1;
        check("mid_rst_req", dmem_req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_valid", wb_valid, 0);
        @(negedge clk);
        reset = 1'b1; MemWrite_in = 0; dmem_ack = 1'b1;
        alu_result_in = 32'h0000_0077;
        #1;
        check("post_rst_stall", stall, 0);
        @(posedge clk); #1;
        check("post_rst_req", dmem_req, 0);
        check("post_rst_bus_err", bus_err, 0);
        check("post_rst_valid", wb_valid, 1);
        check("post_rst_alu", wb_alu_result, 32'h0000_0077);
        dmem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
